fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_sat_counter16.sv | 22 ++
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes,
// fetch FSM state encoding and the bubble instruction used on a flush.
package fetch_unit_pkg;

   localparam logic [2:0] NPC_SEQ    = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JAL    = 3'b010;
   localparam logic [2:0] NPC_JALR   = 3'b100;
   localparam logic [2:0] NPC_STALL  = 3'b111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } fetch_state_t;

   // True for the select codes that move the PC somewhere other than PC+4
   function automatic logic isRedirect(input logic [2:0] op);
      return (op == NPC_BRANCH) || (op == NPC_JAL) || (op == NPC_JALR);
   endfunction

endpackage

// File: rtl/fetch_unit_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_inc,
   output logic [15:0] o_count
);

   logic [15:0] r_count;

   // Count one per cycle with i_inc high, freezing once the maximum is reached
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 16'd0;
      end else if (i_inc && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// handshake, and fills the IF/ID pipeline register. A small FSM copes with
// memory wait states, decode back-pressure and redirects that arrive while
// a request is still outstanding.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  NPCOp,
   input  logic        PC_Write,
   input  logic        IF_ID_Write,
   input  logic        IF_ID_Flush,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] jalr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   fetch_state_t r_state;
   fetch_state_t w_nextState;

   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic [31:0] r_target;
   logic [31:0] r_ifPc;
   logic [31:0] r_ifInst;
   logic        r_ifValid;

   logic        w_redirect;
   logic        w_advance;
   logic [31:0] w_target;
   logic        w_req;
   logic        w_pcLoad;
   logic [31:0] w_pcNext;
   logic        w_bufLoad;
   logic        w_tgtLoad;
   logic        w_ifLoad;
   logic [31:0] w_ifData;

   assign w_redirect = PC_Write && isRedirect(NPCOp);
   assign w_advance  = PC_Write && (NPCOp == NPC_SEQ);
   assign w_target   = (NPCOp == NPC_JALR) ? (jalr_target & 32'hFFFF_FFFE)
                                           : (ex_pc + ex_imm);

   // FSM state register; reset drops straight back to BOOT, abandoning any request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and datapath controls: decide where the fetched word goes and what the PC becomes
   always_comb begin
      w_nextState = r_state;
      w_req       = 1'b0;
      w_pcLoad    = 1'b0;
      w_pcNext    = r_pc;
      w_bufLoad   = 1'b0;
      w_tgtLoad   = 1'b0;
      w_ifLoad    = 1'b0;
      w_ifData    = imem_rdata;
      case (r_state)
         BOOT: begin
            if (w_redirect) begin
               w_pcLoad = 1'b1;
               w_pcNext = w_target;
            end
            w_nextState = REQ;
         end
         REQ: begin
            w_req = 1'b1;
            if (imem_ready) begin
               if (w_redirect) begin
                  w_pcLoad = 1'b1;
                  w_pcNext = w_target;
               end else if (IF_ID_Write && w_advance) begin
                  w_ifLoad = 1'b1;
                  w_pcLoad = 1'b1;
                  w_pcNext = r_pc + 32'd4;
               end else begin
                  w_bufLoad   = 1'b1;
                  w_nextState = HOLD;
               end
            end else if (w_redirect) begin
               w_tgtLoad   = 1'b1;
               w_nextState = KILL;
            end
         end
         HOLD: begin
            if (w_redirect) begin
               w_pcLoad    = 1'b1;
               w_pcNext    = w_target;
               w_nextState = REQ;
            end else if (IF_ID_Write && w_advance) begin
               w_ifLoad    = 1'b1;
               w_ifData    = r_buf;
               w_pcLoad    = 1'b1;
               w_pcNext    = r_pc + 32'd4;
               w_nextState = REQ;
            end
         end
         KILL: begin
            w_req = 1'b1;
            if (imem_ready) begin
               w_pcLoad    = 1'b1;
               w_pcNext    = w_redirect ? w_target : r_target;
               w_nextState = REQ;
            end else if (w_redirect) begin
               w_tgtLoad = 1'b1;
            end
         end
         default: begin
            w_nextState = BOOT;
         end
      endcase
   end

   // PC, skid buffer and pending redirect target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_buf    <= 32'd0;
         r_target <= 32'd0;
      end else begin
         if (w_pcLoad) begin
            r_pc <= w_pcNext;
         end
         if (w_bufLoad) begin
            r_buf <= imem_rdata;
         end
         if (w_tgtLoad) begin
            r_target <= w_target;
         end
      end
   end

   // IF/ID register: a flush turns the slot into a bubble and beats any load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifPc    <= 32'd0;
         r_ifInst  <= NOP_INST;
         r_ifValid <= 1'b0;
      end else if (IF_ID_Flush) begin
         r_ifInst  <= NOP_INST;
         r_ifValid <= 1'b0;
      end else if (w_ifLoad) begin
         r_ifPc    <= r_pc;
         r_ifInst  <= w_ifData;
         r_ifValid <= 1'b1;
      end
   end

   sat_counter16 u_stallCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (NPCOp == NPC_STALL),
      .o_count (stall_cnt)
   );

   sat_counter16 u_flushCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (IF_ID_Flush),
      .o_count (flush_cnt)
   );

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign if_id_pc    = r_ifPc;
   assign if_id_inst  = r_ifInst;
   assign if_id_valid = r_ifValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Inputs change and outputs are sampled on
// the falling clock edge; the instruction memory is a pure function of address.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  NPCOp;
   logic        PC_Write;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] jalr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int nChecks = 0;
   int nErrors = 0;

   // Instruction word stored at a given address
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hCAFE_0000;
   endfunction

   assign imem_rdata = memWord(imem_addr);

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .NPCOp       (NPCOp),
      .PC_Write    (PC_Write),
      .IF_ID_Write (IF_ID_Write),
      .IF_ID_Flush (IF_ID_Flush),
      .ex_pc       (ex_pc),
      .ex_imm      (ex_imm),
      .jalr_target (jalr_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .if_id_valid (if_id_valid),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a broken design can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Reset state while rst_n is held low
   task automatic test_reset();
      step();
      step();
      nChecks++; if (imem_req !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
      nChecks++; if (imem_addr !== 32'h0) begin nErrors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
      nChecks++; if (if_id_pc !== 32'h0) begin nErrors++; $display("[TB] FAIL reset_ifpc: got %h expected 00000000", if_id_pc); end
      nChecks++; if (if_id_inst !== 32'h13) begin nErrors++; $display("[TB] FAIL reset_inst: got %h expected 00000013", if_id_inst); end
      nChecks++; if (if_id_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
      nChecks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin nErrors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
      rst_n = 1'b1;
   endtask

   // Memory always ready: one fetch per cycle, IF/ID one cycle behind
   task automatic test_sequential();
      step();
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nErrors++; $display("[TB] FAIL seq_first: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
      step();
      nChecks++; if (imem_addr !== 32'h4) begin nErrors++; $display("[TB] FAIL seq_addr4: got %h expected 00000004", imem_addr); end
      nChecks++; if (if_id_pc !== 32'h0 || if_id_inst !== memWord(32'h0) || if_id_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL seq_ifid0: got pc=%h inst=%h v=%b expected pc=00000000 inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, memWord(32'h0)); end
      step();
      nChecks++; if (imem_addr !== 32'h8 || if_id_pc !== 32'h4) begin nErrors++; $display("[TB] FAIL seq_addr8: got addr=%h pc=%h expected addr=00000008 pc=00000004", imem_addr, if_id_pc); end
   endtask

   // Three wait states at 0x8: address held, IF/ID loads only on the ready cycle
   task automatic test_wait();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_id_pc !== 32'h4) begin nErrors++; $display("[TB] FAIL wait_hold%0d: got req=%b addr=%h pc=%h expected req=1 addr=00000008 pc=00000004", i, imem_req, imem_addr, if_id_pc); end
      end
      imem_ready = 1'b1;
      step();
      nChecks++; if (imem_addr !== 32'hC || if_id_pc !== 32'h8 || if_id_inst !== memWord(32'h8)) begin nErrors++; $display("[TB] FAIL wait_done: got addr=%h pc=%h inst=%h expected addr=0000000c pc=00000008 inst=%h", imem_addr, if_id_pc, if_id_inst, memWord(32'h8)); end
   endtask

   // Decode stall for two cycles: word parked in the buffer, released later
   task automatic test_stall_hold();
      NPCOp = 3'b111; PC_Write = 1'b0; IF_ID_Write = 1'b0;
      step();
      nChecks++; if (imem_req !== 1'b0 || imem_addr !== 32'hC) begin nErrors++; $display("[TB] FAIL hold_enter: got req=%b addr=%h expected req=0 addr=0000000c", imem_req, imem_addr); end
      step();
      nChecks++; if (stall_cnt !== 16'd2) begin nErrors++; $display("[TB] FAIL hold_stallcnt: got %0d expected 2", stall_cnt); end
      nChecks++; if (imem_addr !== 32'hC || if_id_pc !== 32'h8) begin nErrors++; $display("[TB] FAIL hold_pc: got addr=%h pc=%h expected addr=0000000c pc=00000008", imem_addr, if_id_pc); end
      NPCOp = 3'b000; PC_Write = 1'b1; IF_ID_Write = 1'b1;
      step();
      nChecks++; if (if_id_pc !== 32'hC || if_id_inst !== memWord(32'hC) || if_id_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL hold_release: got pc=%h inst=%h v=%b expected pc=0000000c inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, memWord(32'hC)); end
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || stall_cnt !== 16'd2) begin nErrors++; $display("[TB] FAIL hold_resume: got req=%b addr=%h stall=%0d expected req=1 addr=00000010 stall=2", imem_req, imem_addr, stall_cnt); end
   endtask

   // Taken branch with flush: target fetched next, IF/ID becomes a bubble
   task automatic test_branch_flush();
      NPCOp = 3'b001; ex_pc = 32'h40; ex_imm = 32'h20; IF_ID_Flush = 1'b1;
      step();
      nChecks++; if (imem_addr !== 32'h60) begin nErrors++; $display("[TB] FAIL br_target: got %h expected 00000060", imem_addr); end
      nChecks++; if (if_id_inst !== 32'h13 || if_id_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL br_flush: got inst=%h v=%b expected inst=00000013 v=0", if_id_inst, if_id_valid); end
      nChecks++; if (flush_cnt !== 16'd1) begin nErrors++; $display("[TB] FAIL br_flushcnt: got %0d expected 1", flush_cnt); end
      NPCOp = 3'b000; IF_ID_Flush = 1'b0;
      step();
      nChecks++; if (if_id_pc !== 32'h60 || if_id_valid !== 1'b1 || imem_addr !== 32'h64) begin nErrors++; $display("[TB] FAIL br_after: got pc=%h v=%b addr=%h expected pc=00000060 v=1 addr=00000064", if_id_pc, if_id_valid, imem_addr); end
   endtask

   // jal whose target wraps past 2^32; fetched word is discarded
   task automatic test_jal_wrap();
      NPCOp = 3'b010; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
      step();
      nChecks++; if (imem_addr !== 32'h10 || if_id_pc !== 32'h60) begin nErrors++; $display("[TB] FAIL jal_wrap: got addr=%h pc=%h expected addr=00000010 pc=00000060", imem_addr, if_id_pc); end
      NPCOp = 3'b000;
      step();
      nChecks++; if (if_id_pc !== 32'h10 || imem_addr !== 32'h14) begin nErrors++; $display("[TB] FAIL jal_after: got pc=%h addr=%h expected pc=00000010 addr=00000014", if_id_pc, imem_addr); end
   endtask

   // jalr while memory stalls: old address kept, stale word dropped, LSB cleared
   task automatic test_jalr_kill();
      imem_ready = 1'b0; NPCOp = 3'b100; jalr_target = 32'h105;
      step();
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin nErrors++; $display("[TB] FAIL kill_keep: got req=%b addr=%h expected req=1 addr=00000014", imem_req, imem_addr); end
      NPCOp = 3'b000;
      step();
      nChecks++; if (imem_addr !== 32'h14) begin nErrors++; $display("[TB] FAIL kill_wait: got %h expected 00000014", imem_addr); end
      imem_ready = 1'b1;
      step();
      nChecks++; if (imem_addr !== 32'h104 || if_id_pc !== 32'h10) begin nErrors++; $display("[TB] FAIL kill_drop: got addr=%h pc=%h expected addr=00000104 pc=00000010", imem_addr, if_id_pc); end
      step();
      nChecks++; if (if_id_pc !== 32'h104 || if_id_inst !== memWord(32'h104)) begin nErrors++; $display("[TB] FAIL kill_after: got pc=%h inst=%h expected pc=00000104 inst=%h", if_id_pc, if_id_inst, memWord(32'h104)); end
   endtask

   // A later redirect during KILL replaces the pending target
   task automatic test_kill_overwrite();
      imem_ready = 1'b0; NPCOp = 3'b100; jalr_target = 32'h301;
      step();
      NPCOp = 3'b001; ex_pc = 32'h200; ex_imm = 32'h8;
      step();
      nChecks++; if (imem_addr !== 32'h108) begin nErrors++; $display("[TB] FAIL ovr_keep: got %h expected 00000108", imem_addr); end
      NPCOp = 3'b000; imem_ready = 1'b1;
      step();
      nChecks++; if (imem_addr !== 32'h208 || if_id_pc !== 32'h104) begin nErrors++; $display("[TB] FAIL ovr_target: got addr=%h pc=%h expected addr=00000208 pc=00000104", imem_addr, if_id_pc); end
   endtask

   // Reset during a memory wait: request dropped at once, clean restart
   task automatic test_reset_midfetch();
      imem_ready = 1'b0;
      step();
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h208) begin nErrors++; $display("[TB] FAIL mid_pending: got req=%b addr=%h expected req=1 addr=00000208", imem_req, imem_addr); end
      rst_n = 1'b0;
      #1;
      nChecks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin nErrors++; $display("[TB] FAIL mid_async: got req=%b addr=%h expected req=0 addr=00000000", imem_req, imem_addr); end
      nChecks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin nErrors++; $display("[TB] FAIL mid_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
      nChecks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h13) begin nErrors++; $display("[TB] FAIL mid_ifid: got v=%b inst=%h expected v=0 inst=00000013", if_id_valid, if_id_inst); end
      imem_ready = 1'b1;
      step();
      nChecks++; if (imem_req !== 1'b0) begin nErrors++; $display("[TB] FAIL mid_held: got %b expected 0", imem_req); end
      rst_n = 1'b1;
      step();
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nErrors++; $display("[TB] FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
      step();
      nChecks++; if (if_id_pc !== 32'h0 || if_id_inst !== memWord(32'h0) || imem_addr !== 32'h4) begin nErrors++; $display("[TB] FAIL mid_first: got pc=%h inst=%h addr=%h expected pc=00000000 inst=%h addr=00000004", if_id_pc, if_id_inst, imem_addr, memWord(32'h0)); end
   endtask

   // Run every scenario back to back and report
   initial begin
      rst_n = 1'b0;
      NPCOp = 3'b000;
      PC_Write = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ex_pc = 32'h0;
      ex_imm = 32'h0;
      jalr_target = 32'h0;
      imem_ready = 1'b1;
      test_reset();
      test_sequential();
      test_wait();
      test_stall_hold();
      test_branch_flush();
      test_jal_wrap();
      test_jalr_kill();
      test_kill_overwrite();
      test_reset_midfetch();
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
